// File: rtl/sdram_burst_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_burst_scheduler : round-robin page-burst scheduler for 2 write + 2 read ports
// rev 1.0
// ---------------------------------------------------------------------------
module sdram_burst_scheduler #(
    parameter int ASIZE      = 23,
    parameter int FIFO_DEPTH = 512,
    parameter int TIMEOUT    = 1023
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic [ASIZE-1:0] BASE_ADDR1,
    input  logic [ASIZE-1:0] BASE_ADDR2,
    input  logic [ASIZE-1:0] MAX_ADDR1,
    input  logic [ASIZE-1:0] MAX_ADDR2,
    input  logic [8:0]       BURST_LEN,
    input  logic [9:0]       WR_LEVEL1,
    input  logic [9:0]       WR_LEVEL2,
    input  logic [9:0]       RD_LEVEL1,
    input  logic [9:0]       RD_LEVEL2,
    input  logic             CORE_IDLE,
    input  logic             WR_DONE,
    input  logic             RD_DONE,
    output logic             REQ_WR,
    output logic             REQ_RD,
    output logic [ASIZE-1:0] REQ_ADDR,
    output logic [8:0]       REQ_LEN,
    output logic [1:0]       WR_MASK,
    output logic [1:0]       RD_MASK,
    output logic             TIMEOUT_ERR
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, COOL = 2'd2} state_t;

    localparam logic [1:0]    P_W1    = 2'd0;
    localparam logic [1:0]    P_W2    = 2'd1;
    localparam logic [1:0]    P_R1    = 2'd2;
    localparam logic [1:0]    P_R2    = 2'd3;
    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [10:0]   DEPTH11 = 11'(FIFO_DEPTH);

    state_t            state, state_next;
    logic [ASIZE-1:0]  wp1, wp2, rp1, rp2;
    logic [8:0]        len_r;
    logic [1:0]        last_grant, winner, pick;
    logic [1:0]        c1, c2, c3;
    logic [3:0]        elig;
    logic [WD_W-1:0]   wdog;
    logic              len_nz, done_match;
    logic              do_grant, do_done, do_abort;
    logic              req_wr, req_rd, timeout_err;
    logic [1:0]        wr_mask, rd_mask;
    logic [ASIZE-1:0]  req_addr, grant_ptr;
    logic [8:0]        req_len;

    // Read FIFOs need room for a whole burst; the sum is kept at 11 bits so it never wraps.
    assign len_nz  = (len_r != 9'd0);
    assign elig[0] = len_nz && (WR_LEVEL1 >= {1'b0, len_r});
    assign elig[1] = len_nz && (WR_LEVEL2 >= {1'b0, len_r});
    assign elig[2] = len_nz && (({1'b0, RD_LEVEL1} + {2'b00, len_r}) <= DEPTH11);
    assign elig[3] = len_nz && (({1'b0, RD_LEVEL2} + {2'b00, len_r}) <= DEPTH11);

    assign c1 = last_grant + 2'd1;
    assign c2 = last_grant + 2'd2;
    assign c3 = last_grant + 2'd3;

    always_comb begin
        pick = last_grant;
        if (elig[c1])      pick = c1;
        else if (elig[c2]) pick = c2;
        else if (elig[c3]) pick = c3;
    end

    always_comb begin
        case (pick)
            P_W1:    grant_ptr = wp1;
            P_W2:    grant_ptr = wp2;
            P_R1:    grant_ptr = rp1;
            default: grant_ptr = rp2;
        endcase
    end

    assign done_match = winner[1] ? RD_DONE : WR_DONE;

    function automatic logic [ASIZE-1:0] advance(input logic [ASIZE-1:0] ptr,
                                                 input logic [ASIZE-1:0] base,
                                                 input logic [ASIZE-1:0] lim,
                                                 input logic [8:0]       len);
        logic [ASIZE:0] nxt;
        nxt = {1'b0, ptr} + {{(ASIZE - 8){1'b0}}, len};
        return (nxt >= {1'b0, lim}) ? base : nxt[ASIZE-1:0];
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        if (LOAD) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (CORE_IDLE && (|elig)) begin
                    do_grant   = 1'b1;
                    state_next = BUSY;
                end
                BUSY: if (done_match) begin
                    do_done    = 1'b1;
                    state_next = COOL;
                end else if (wdog == WD_LAST) begin
                    do_abort   = 1'b1;
                    state_next = COOL;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp1 <= BASE_ADDR1;  rp1 <= BASE_ADDR1;
            wp2 <= BASE_ADDR2;  rp2 <= BASE_ADDR2;
            len_r       <= BURST_LEN;
            last_grant  <= P_R2;
            winner      <= P_W1;
            wdog        <= '0;
            req_wr      <= 1'b0;
            req_rd      <= 1'b0;
            wr_mask     <= 2'b00;
            rd_mask     <= 2'b00;
            req_addr    <= '0;
            req_len     <= 9'd0;
            timeout_err <= 1'b0;
        end else if (LOAD) begin
            wp1 <= BASE_ADDR1;  rp1 <= BASE_ADDR1;
            wp2 <= BASE_ADDR2;  rp2 <= BASE_ADDR2;
            len_r       <= BURST_LEN;
            wdog        <= '0;
            req_wr      <= 1'b0;
            req_rd      <= 1'b0;
            wr_mask     <= 2'b00;
            rd_mask     <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            if (do_grant) begin
                winner   <= pick;
                req_wr   <= ~pick[1];
                req_rd   <= pick[1];
                wr_mask  <= pick[1] ? 2'b00 : (pick[0] ? 2'b10 : 2'b01);
                rd_mask  <= pick[1] ? (pick[0] ? 2'b10 : 2'b01) : 2'b00;
                req_addr <= grant_ptr;
                req_len  <= len_r;
                wdog     <= '0;
            end
            if (state == BUSY && !do_done && !do_abort) wdog <= wdog + 1'b1;
            if (do_done || do_abort) begin
                req_wr  <= 1'b0;
                req_rd  <= 1'b0;
                wr_mask <= 2'b00;
                rd_mask <= 2'b00;
            end
            if (do_abort) timeout_err <= 1'b1;
            if (do_done) begin
                last_grant <= winner;
                case (winner)
                    P_W1:    wp1 <= advance(wp1, BASE_ADDR1, MAX_ADDR1, len_r);
                    P_W2:    wp2 <= advance(wp2, BASE_ADDR2, MAX_ADDR2, len_r);
                    P_R1:    rp1 <= advance(rp1, BASE_ADDR1, MAX_ADDR1, len_r);
                    default: rp2 <= advance(rp2, BASE_ADDR2, MAX_ADDR2, len_r);
                endcase
            end
        end
    end

    assign REQ_WR      = req_wr;
    assign REQ_RD      = req_rd;
    assign WR_MASK     = wr_mask;
    assign RD_MASK     = rd_mask;
    assign REQ_ADDR    = req_addr;
    assign REQ_LEN     = req_len;
    assign TIMEOUT_ERR = timeout_err;

endmodule
`default_nettype wire

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
- Round-robin burst scheduler for the 4-port SDRAM controller (write ports 1/2, read ports 1/2).
- Watches the FIFO fill levels, chooses which port gets the next page burst, and presents address, length and port mask to the SDRAM command sequencer.
- Manages the wrap-around address pointer for each port.
- Replaces fixed-priority port selection, so a busy write port cannot starve the read ports.

Parameters:
- ASIZE, 23, SDRAM word-address width.
- FIFO_DEPTH, 512, depth of each port FIFO in words.
- TIMEOUT, 1023, maximum cycles in BUSY without a done pulse before abort.

Ports:
- CLK  in  1  controller clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- LOAD  in  1  reload pointers and block arbitration while high.
- BASE_ADDR1  in  ASIZE  region base, port pair 1.
- BASE_ADDR2  in  ASIZE  region base, port pair 2.
- MAX_ADDR1  in  ASIZE  region end (exclusive), pair 1.
- MAX_ADDR2  in  ASIZE  region end (exclusive), pair 2.
- BURST_LEN  in  9  words per burst, captured on LOAD and at reset.
- WR_LEVEL1  in  10  read-side used-words of write FIFO 1.
- WR_LEVEL2  in  10  read-side used-words of write FIFO 2.
- RD_LEVEL1  in  10  write-side used-words of read FIFO 1.
- RD_LEVEL2  in  10  write-side used-words of read FIFO 2.
- CORE_IDLE  in  1  sequencer is in its idle state.
- WR_DONE  in  1  one-cycle pulse: write burst finished.
- RD_DONE  in  1  one-cycle pulse: read burst finished.
- REQ_WR  out  1  write burst request, level.
- REQ_RD  out  1  read burst request, level.
- REQ_ADDR  out  ASIZE  burst start address.
- REQ_LEN  out  9  burst length.
- WR_MASK  out  2  one-hot active write port.
- RD_MASK  out  2  one-hot active read port.
- TIMEOUT_ERR  out  1  sticky abort flag; cleared by LOAD.

Behaviour:

Reset:
- REQ_WR, REQ_RD, WR_MASK, RD_MASK, REQ_ADDR, REQ_LEN and TIMEOUT_ERR are 0.
- Pointers: wp1 and rp1 = BASE_ADDR1; wp2 and rp2 = BASE_ADDR2.
- len_r = BURST_LEN; last_grant = R2, so W1 has first priority; state IDLE.

Eligibility (combinational):
- W1/W2: WR_LEVELx >= len_r and len_r != 0.
- R1/R2: RD_LEVELx + len_r <= FIFO_DEPTH and len_r != 0. This sum is computed at 11 bits.

Round-robin order is W1 -> W2 -> R1 -> R2 -> W1. The search starts at the port after last_grant.

States:
- IDLE:
  - If LOAD=0, CORE_IDLE=1 and any port is eligible, latch the winner.
  - On the same edge, drive REQ_ADDR = that port's pointer and REQ_LEN = len_r.
  - Set the one-hot mask and REQ_WR or REQ_RD; go to BUSY.
  - Latency: eligibility sampled at edge N gives the request visible after edge N.
- BUSY:
  - REQ_*, the masks, address and length stay stable.
  - The matching done pulse (WR_DONE with a write grant, RD_DONE with a read grant) clears REQ_* and the masks on that edge.
  - On that edge, advance the granted pointer, set last_grant = winner, go to COOL.
  - A non-matching done pulse is ignored.
  - The watchdog counter runs while in BUSY. When it reaches TIMEOUT, set TIMEOUT_ERR, clear requests and masks, leave pointers unchanged, go to COOL.
- COOL: one cycle with no request, so the sequencer can re-detect a rising request edge; then IDLE.

Pointer advance:
- next = ptr + len_r, computed at ASIZE+1 bits.
- If next >= MAX_ADDRx, the pointer wraps to BASE_ADDRx; otherwise it takes next.
- Each write and read pointer advances independently.

LOAD:
- Highest priority and synchronous, in any state.
- Reloads all four pointers and len_r, clears the masks, REQ_* and TIMEOUT_ERR, and goes to IDLE.
- last_grant is kept.
- A done pulse on the same edge as LOAD is ignored and gives no pointer advance.
- No grant is made while LOAD is high.

Simultaneous: a done pulse and an eligibility change on the same edge give no grant that cycle. The next grant is no earlier than after COOL.

Reset mid-burst: all state returns immediately to the reset values.

Test Plan:
1. Reset, BASE_ADDR1=0, MAX_ADDR1=0x400, BURST_LEN=256, WR_LEVEL1=256, CORE_IDLE=1 -> after 1 edge REQ_WR=1, WR_MASK=01, REQ_ADDR=0, REQ_LEN=256.
2. Continuation of 1: WR_DONE pulse -> REQ_WR=0 same edge; next W1 grant has REQ_ADDR=0x100; after 0x300 it wraps to 0x000.
3. All four ports eligible continuously, done returned 20 cycles after each request -> grant order W1, W2, R1, R2, W1; no port granted twice before every other eligible port is granted once.
4. RD_LEVEL1=300, BURST_LEN=256, FIFO_DEPTH=512 -> R1 never granted; set RD_LEVEL1=256 -> R1 granted.
5. Grant issued and no done for 1023 cycles -> TIMEOUT_ERR=1, requests cleared, pointer unchanged; LOAD -> TIMEOUT_ERR=0.
6. LOAD asserted in BUSY on the same edge as WR_DONE -> IDLE, pointers equal BASE_ADDRx, no advance; no grant while LOAD=1.
